// File: rtl/bp_update_arbiter_pkg.sv
// bp_update_arbiter_pkg: shared update-entry type and default queue depth
package bp_update_arbiter_pkg;
  localparam int DEPTH_DEF = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } bp_upd_t;
endpackage

// File: rtl/bp_update_arbiter_fifo.sv
// bp_upd_fifo: 2-write/1-read in-order circular fifo (wr0 lands at tail, wr1 after it), count = entries, head = oldest entry
module bp_upd_fifo
  import bp_update_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr0,
  input  bp_upd_t       wr0_data,
  input  logic          wr1,
  input  bp_upd_t       wr1_data,
  input  logic          rd,
  output bp_upd_t       head_data,
  output logic [CW-1:0] count
);
  bp_upd_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  assign head_data = mem[head];
  always_ff @(posedge clk) begin
    if (wr0) mem[tail] <= wr0_data;
    if (wr1) mem[tail + AW'(wr0)] <= wr1_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(rd);
      tail  <= tail + AW'(wr0) + AW'(wr1);
      count <= count + CW'(wr0) + CW'(wr1) - CW'(rd);
    end
  end
endmodule

// File: rtl/bp_update_arbiter.sv
// bp_update_arbiter: two-port branch-update arbiter (upd0/upd1 offers, hold gate) feeding the predictor update port in order, with occupancy and saturating issue count
module bp_update_arbiter
  import bp_update_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd0_valid,
  input  logic [31:0]   upd0_pc,
  input  logic          upd0_taken,
  output logic          upd0_ready,
  input  logic          upd1_valid,
  input  logic [31:0]   upd1_pc,
  input  logic          upd1_taken,
  output logic          upd1_ready,
  input  logic          hold,
  output logic          pred_is_branch,
  output logic [31:0]   pred_pc_to_update,
  output logic          pred_branch_taken,
  output logic [CW-1:0] occupancy,
  output logic [15:0]   upd_count
);
  bp_upd_t head;
  logic [CW-1:0] free;
  logic acc0, acc1, has_entry;
  assign free              = CW'(DEPTH) - occupancy;
  assign has_entry         = occupancy != '0;
  assign upd0_ready        = rst && free != '0;
  assign upd1_ready        = rst && (free > CW'(1) || (free != '0 && !upd0_valid));
  assign acc0              = upd0_valid && upd0_ready;
  assign acc1              = upd1_valid && upd1_ready;
  assign pred_is_branch    = rst && has_entry && !hold;
  assign pred_pc_to_update = has_entry ? head.pc : 32'd0;
  assign pred_branch_taken = has_entry ? head.taken : 1'b0;
  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0      (acc0),
    .wr0_data ('{pc: upd0_pc, taken: upd0_taken}),
    .wr1      (acc1),
    .wr1_data ('{pc: upd1_pc, taken: upd1_taken}),
    .rd       (pred_is_branch),
    .head_data(head),
    .count    (occupancy)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) upd_count <= '0;
    else if (pred_is_branch && upd_count != 16'hFFFF) upd_count <= upd_count + 16'd1;
  end
endmodule

// File: tb/tb_bp_update_arbiter.sv
// tb_bp_update_arbiter: scoreboard bench for bp_update_arbiter
`timescale 1ns/1ps
module tb_bp_update_arbiter;
  import bp_update_arbiter_pkg::*;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, rst = 1'b0;
  logic upd0_valid = 1'b0, upd0_taken = 1'b0, upd1_valid = 1'b0, upd1_taken = 1'b0, hold = 1'b0;
  logic [31:0] upd0_pc = '0, upd1_pc = '0;
  logic upd0_ready, upd1_ready, pred_is_branch, pred_branch_taken;
  logic [31:0] pred_pc_to_update;
  logic [CW-1:0] occupancy;
  logic [15:0] upd_count;
  int checks = 0, failures = 0;
  int m_occ = 0, m_cnt = 0;
  bp_upd_t sb [$];
  bp_update_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .upd0_valid(upd0_valid), .upd0_pc(upd0_pc), .upd0_taken(upd0_taken), .upd0_ready(upd0_ready),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken), .upd1_ready(upd1_ready),
    .hold(hold), .pred_is_branch(pred_is_branch), .pred_pc_to_update(pred_pc_to_update),
    .pred_branch_taken(pred_branch_taken), .occupancy(occupancy), .upd_count(upd_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic v0, input logic [31:0] p0, input logic t0,
                       input logic v1, input logic [31:0] p1, input logic t1);
    upd0_valid = v0; upd0_pc = p0; upd0_taken = t0;
    upd1_valid = v1; upd1_pc = p1; upd1_taken = t1;
  endtask
  // reference model: evaluated mid-cycle, predicts the coming edge
  always @(negedge clk) begin
    int free;
    bp_upd_t e;
    if (!rst) begin
      chk("rst_r0", 32'(upd0_ready), 0);
      chk("rst_r1", 32'(upd1_ready), 0);
      chk("rst_pib", 32'(pred_is_branch), 0);
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_cnt", 32'(upd_count), 0);
      m_occ = 0; m_cnt = 0; sb.delete();
    end else begin
      free = DEPTH - m_occ;
      chk("occ", 32'(occupancy), 32'(m_occ));
      chk("cnt", 32'(upd_count), 32'(m_cnt));
      chk("r0", 32'(upd0_ready), 32'(free >= 1));
      chk("r1", 32'(upd1_ready), 32'(free >= 2 || (free >= 1 && !upd0_valid)));
      chk("pib", 32'(pred_is_branch), 32'(m_occ != 0 && !hold));
      if (m_occ == 0) begin
        chk("empty_pc", pred_pc_to_update, 0);
        chk("empty_tk", 32'(pred_branch_taken), 0);
      end else if (!hold) begin
        e = sb.pop_front();
        chk("iss_pc", pred_pc_to_update, e.pc);
        chk("iss_tk", 32'(pred_branch_taken), 32'(e.taken));
        m_occ--;
        if (m_cnt < 16'hFFFF) m_cnt++;
      end
      if (upd0_valid && free >= 1) begin
        sb.push_back('{pc: upd0_pc, taken: upd0_taken});
        m_occ++;
      end
      if (upd1_valid && (free >= 2 || (free >= 1 && !upd0_valid))) begin
        sb.push_back('{pc: upd1_pc, taken: upd1_taken});
        m_occ++;
      end
    end
  end
  initial begin
    int n;
    cyc(2);
    rst = 1'b1;
    cyc();
    chk("post_rst_occ", 32'(occupancy), 0);
    drive(1, 32'h100, 1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("single_pib", 32'(pred_is_branch), 1);
    chk("single_pc", pred_pc_to_update, 32'h100);
    chk("single_tk", 32'(pred_branch_taken), 1);
    cyc();
    chk("single_empty", 32'(pred_is_branch), 0);
    chk("single_cnt", 32'(upd_count), 1);
    drive(1, 32'h200, 1, 1, 32'h204, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("pair_pc0", pred_pc_to_update, 32'h200);
    cyc();
    chk("pair_pc1", pred_pc_to_update, 32'h204);
    chk("pair_tk1", 32'(pred_branch_taken), 0);
    cyc();
    chk("pair_empty", 32'(occupancy), 0);
    hold = 1'b1;
    drive(1, 32'h300, 0, 1, 32'h304, 1);
    cyc();
    drive(1, 32'h308, 1, 0, 0, 0);
    cyc();
    chk("near_full_occ", 32'(occupancy), DEPTH - 1);
    hold = 1'b0;
    drive(1, 32'h30C, 0, 1, 32'h310, 1);
    #1;
    chk("near_full_r0", 32'(upd0_ready), 1);
    chk("near_full_r1", 32'(upd1_ready), 0);
    cyc();
    drive(0, 0, 0, 1, 32'h310, 1);
    #1;
    chk("retry_r1", 32'(upd1_ready), 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc(DEPTH + 1);
    chk("drain_occ", 32'(occupancy), 0);
    hold = 1'b1;
    drive(1, 32'h400, 1, 1, 32'h404, 0);
    cyc();
    drive(1, 32'h408, 0, 1, 32'h40C, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("hold_pib", 32'(pred_is_branch), 0);
      chk("hold_r0", 32'(upd0_ready), 0);
      chk("hold_r1", 32'(upd1_ready), 0);
      chk("hold_occ", 32'(occupancy), DEPTH);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    hold = 1'b0;
    cyc(DEPTH);
    chk("hold_drained", 32'(occupancy), 0);
    hold = 1'b1;
    drive(1, 32'h500, 1, 1, 32'h504, 1);
    cyc();
    drive(1, 32'h508, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    hold = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 3);
    #1;
    rst = 1'b0;
    #1;
    chk("async_occ", 32'(occupancy), 0);
    chk("async_pib", 32'(pred_is_branch), 0);
    chk("async_r0", 32'(upd0_ready), 0);
    cyc(2);
    rst = 1'b1;
    cyc();
    chk("rst_discard_occ", 32'(occupancy), 0);
    n = 0;
    while (upd_count != 16'hFFFE && n < 70000) begin
      drive(1, 32'(n), n[0], 0, 0, 0);
      cyc();
      n++;
    end
    chk("pre_sat_cnt", 32'(upd_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hA000 + 32'(i), 1, 0, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    cyc(DEPTH);
    chk("sat_cnt", 32'(upd_count), 32'hFFFF);
    cyc();
    chk("sat_hold_cnt", 32'(upd_count), 32'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
